// File: rtl/contador_bcd_mod_param.sv
// rtl/contador_bcd_mod_param.sv - selectable BCD up/down counter with load and wrap pulse
// Optional auto-repeat of held requests: define CONTADOR_BCD_AUTOREPEAT_EN.
module contador_bcd_mod_param #(
  parameter int MOD_MIN  = 0,
  parameter int MOD_MAX  = 59,
  parameter int WIDTH    = 7,
  parameter int FIELD_ID = 8,
  parameter int TICK_DIV = 13000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       en_count,
  input  logic             enUP,
  input  logic             enDOWN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       digit1,
  output logic [3:0]       digit0,
  output logic             wrap
);

  localparam logic [WIDTH-1:0]   MIN_V   = WIDTH'(MOD_MIN);
  localparam logic [WIDTH-1:0]   MAX_V   = WIDTH'(MOD_MAX);
  localparam logic signed [WIDTH:0] MIN_S = (WIDTH+1)'(MOD_MIN);
  localparam logic signed [WIDTH:0] MAX_S = (WIDTH+1)'(MOD_MAX);
  localparam logic [3:0]         FIELD_V = 4'(FIELD_ID);

  generate
    if (MOD_MIN < 0 || MOD_MIN >= MOD_MAX || MOD_MAX > 99) begin : g_bad_range
      $error("contador_bcd_mod_param: need 0 <= MOD_MIN < MOD_MAX <= 99");
    end
    if (MOD_MAX >= (1 << WIDTH)) begin : g_bad_width
      $error("contador_bcd_mod_param: WIDTH too small for MOD_MAX");
    end
    if (TICK_DIV < 2) begin : g_bad_div
      $error("contador_bcd_mod_param: TICK_DIV must be >= 2");
    end
  endgenerate

  logic active;
  logic up_req;
  logic dn_req;
  logic up_q;
  logic dn_q;
  logic up_edge;
  logic dn_edge;
  logic step_up;
  logic step_dn;
  logic in_range;
  logic signed [WIDTH:0] load_s;
  logic [7:0] cnt8;

  // Up wins when both buttons are held.
  assign active  = (en_count == FIELD_V);
  assign up_req  = active & enUP;
  assign dn_req  = active & enDOWN & ~enUP;
  assign up_edge = up_req & ~up_q;
  assign dn_edge = dn_req & ~dn_q;

  assign load_s   = $signed({1'b0, load_val});
  assign in_range = (load_s >= MIN_S) && (load_s <= MAX_S);

`ifdef CONTADOR_BCD_AUTOREPEAT_EN
  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Restarts on every fresh press so the first repeat lands TICK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (load || up_edge || dn_edge || !(up_req || dn_req) || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign step_up = up_edge | (tick & up_req);
  assign step_dn = dn_edge | (tick & dn_req);
`else
  assign step_up = up_edge;
  assign step_dn = dn_edge;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= MIN_V;
      wrap  <= 1'b0;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      up_q <= up_req;
      dn_q <= dn_req;
      wrap <= 1'b0;
      if (load) begin
        count <= in_range ? load_val : MIN_V;
      end else if (step_up) begin
        if (count == MAX_V) begin
          count <= MIN_V;
          wrap  <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (step_dn) begin
        if (count == MIN_V) begin
          count <= MAX_V;
          wrap  <= 1'b1;
        end else begin
          count <= count - 1'b1;
        end
      end
    end
  end

  assign cnt8   = 8'(count);
  assign digit1 = 4'(cnt8 / 8'd10);
  assign digit0 = 4'(cnt8 % 8'd10);

endmodule

// File: tb/tb_contador_bcd_mod_param.sv
// tb/tb_contador_bcd_mod_param.sv - directed self-checking bench for contador_bcd_mod_param
module tb_contador_bcd_mod_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] en_count;
  logic       enUP, enDOWN, load;
  logic [6:0] load_val;
  logic [6:0] count;
  logic [3:0] digit1, digit0;
  logic       wrap;

  logic       b_reset;
  logic [3:0] b_en_count;
  logic       b_enUP, b_enDOWN, b_load;
  logic [5:0] b_load_val;
  logic [5:0] b_count;
  logic [3:0] b_digit1, b_digit0;
  logic       b_wrap;

  int checks = 0;
  int errors = 0;

`ifdef CONTADOR_BCD_AUTOREPEAT_EN
  localparam int HOLD5_EXP = 12;
  localparam int HOLD9_EXP = 13;
`else
  localparam int HOLD5_EXP = 11;
  localparam int HOLD9_EXP = 11;
`endif

  always #5 clk = ~clk;

  contador_bcd_mod_param #(.TICK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN),
    .load(load), .load_val(load_val), .count(count), .digit1(digit1),
    .digit0(digit0), .wrap(wrap)
  );

  contador_bcd_mod_param #(.MOD_MIN(1), .MOD_MAX(31), .WIDTH(6), .TICK_DIV(4)) dut_b (
    .clk(clk), .reset(b_reset), .en_count(b_en_count), .enUP(b_enUP), .enDOWN(b_enDOWN),
    .load(b_load), .load_val(b_load_val), .count(b_count), .digit1(b_digit1),
    .digit0(b_digit0), .wrap(b_wrap)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_a(input string tag, input int c, input int w);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".digit1"}, int'(digit1), c / 10);
    check({tag, ".digit0"}, int'(digit0), c % 10);
    check({tag, ".wrap"}, int'(wrap), w);
  endtask

  task automatic load_a(input int v);
    load_val = 7'(v);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en_count = 4'd8; enUP = 1'b0; enDOWN = 1'b0; load = 1'b0; load_val = '0;
    b_reset = 1'b1; b_en_count = 4'd8; b_enUP = 1'b0; b_enDOWN = 1'b0; b_load = 1'b0; b_load_val = '0;
    cyc();
    check_a("reset", 0, 0);
    check("b_reset.count", int'(b_count), 1);
    check("b_reset.digit0", int'(b_digit0), 1);
    reset = 1'b0; b_reset = 1'b0;

    enUP = 1'b1; cyc(); check_a("first_up", 1, 0);
    enUP = 1'b0; cyc();

    load_a(59); check_a("load59", 59, 0);
    enUP = 1'b1; cyc(); check_a("up_wrap", 0, 1);
    enUP = 1'b0; cyc(); check_a("wrap_one_cycle", 0, 0);
    enDOWN = 1'b1; cyc(); check_a("down_wrap", 59, 1);
    enDOWN = 1'b0; cyc(); check("down_wrap_clear", int'(wrap), 0);

    load_a(10);
    enUP = 1'b1;
    cyc(5); check("hold5", int'(count), HOLD5_EXP);
    cyc(4); check("hold9", int'(count), HOLD9_EXP);
    enUP = 1'b0; cyc(); check("hold_release", int'(count), HOLD9_EXP);

    load_a(20);
    enUP = 1'b1; enDOWN = 1'b1; cyc(); check("both_up_wins", int'(count), 21);
    enUP = 1'b0; enDOWN = 1'b0; cyc();
    en_count = 4'd3; enUP = 1'b1; cyc(); check("deselected", int'(count), 21);
    enUP = 1'b0; cyc(); en_count = 4'd8;

    enUP = 1'b1; cyc(); check("sel_press", int'(count), 22);
    en_count = 4'd3; cyc(); check("sel_drop", int'(count), 22);
    en_count = 4'd8; cyc(); check("reselect_edge", int'(count), 23);
    enUP = 1'b0; enDOWN = 1'b1; cyc(); check("dir_change", int'(count), 22);
    enDOWN = 1'b0; cyc();

    load_a(75); check_a("load_oor", 0, 0);
    enUP = 1'b1; load_val = 7'd5; load = 1'b1; cyc(); load = 1'b0;
    check("load_over_step", int'(count), 5);
    cyc(); check("no_edge_after_load", int'(count), 5);
    enUP = 1'b0; cyc();

    load_a(36);
    enUP = 1'b1; cyc(); check("to37", int'(count), 37);
    reset = 1'b1; cyc(); check_a("reset_mid_hold", 0, 0);
    reset = 1'b0; cyc(); check_a("edge_after_reset", 1, 0);
    enUP = 1'b0; cyc();

    b_load_val = 6'd45; b_load = 1'b1; cyc(); b_load = 1'b0;
    check("b_load_oor", int'(b_count), 1);
    b_enDOWN = 1'b1; cyc();
    check("b_down_wrap.count", int'(b_count), 31);
    check("b_down_wrap.digit1", int'(b_digit1), 3);
    check("b_down_wrap.digit0", int'(b_digit0), 1);
    check("b_down_wrap.wrap", int'(b_wrap), 1);
    b_enDOWN = 1'b0; cyc();
    b_enUP = 1'b1; cyc(); check("b_up_wrap", int'(b_count), 1);
    b_enUP = 1'b0; cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
